regfile_commit_sequencer: RTL and testbench

//  Sits between the commit stage and the 6-read/4-write physical register file (64x32).

---
 rtl/regfile_commit_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_regfile_commit_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_commit_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_commit_sequencer
//
// Purpose:
//   Buffers one commit group (up to 4 lanes of sel/data) and drains it into the
//   physical register file, N_WRITE lanes per cycle. Pending lanes are compacted
//   onto write ports 0..N_WRITE-1 in lane order, because the register file only
//   honours those ports. Also reports whether a queried register still has a
//   buffered value that has not been written yet.
//
// Parameters:
//   N_WRITE  usable register-file write ports per cycle (legal 1..4)
//   ADDR_W   physical register select width
//   DATA_W   register data width
//
// Ports:
//   clk                       clock, all state on posedge
//   reset                     synchronous, active-high
//   en                        global enable; 0 freezes all state and the handshake
//   inValid / inReady         commit-group handshake (inReady is combinational)
//   inVec[0:3]                lane valid mask, bit 0 = lane 0
//   inSel0..3 / inData0..3    destination register and result per lane
//   commitAllow               register-file write strobe
//   commitVec[0:3]            per-port write enable, bit 0 = port 0
//   writeSelect0..3           per-port destination register
//   writeData0..3             per-port write data
//   busy                      a group is still draining
//   queryReg / queryPending   "does queryReg still have an unwritten buffered value"
// -----------------------------------------------------------------------------
module regfile_commit_sequencer #(
    parameter int N_WRITE = 1,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,

    input  logic              inValid,
    output logic              inReady,
    input  logic [0:3]        inVec,
    input  logic [ADDR_W-1:0] inSel0,
    input  logic [ADDR_W-1:0] inSel1,
    input  logic [ADDR_W-1:0] inSel2,
    input  logic [ADDR_W-1:0] inSel3,
    input  logic [DATA_W-1:0] inData0,
    input  logic [DATA_W-1:0] inData1,
    input  logic [DATA_W-1:0] inData2,
    input  logic [DATA_W-1:0] inData3,

    output logic              commitAllow,
    output logic [0:3]        commitVec,
    output logic [ADDR_W-1:0] writeSelect0,
    output logic [ADDR_W-1:0] writeSelect1,
    output logic [ADDR_W-1:0] writeSelect2,
    output logic [ADDR_W-1:0] writeSelect3,
    output logic [DATA_W-1:0] writeData0,
    output logic [DATA_W-1:0] writeData1,
    output logic [DATA_W-1:0] writeData2,
    output logic [DATA_W-1:0] writeData3,

    output logic              busy,
    input  logic [ADDR_W-1:0] queryReg,
    output logic              queryPending
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Port count as a 3-bit value so comparisons against lane counts stay width-matched.
    localparam logic [2:0] NW = 3'(N_WRITE);

    state_t            state;
    state_t            stateNext;
    logic [0:3]        pendMask;
    logic [0:3]        pendNext;
    logic              loadBuf;
    logic [ADDR_W-1:0] selBuf  [4];
    logic [DATA_W-1:0] dataBuf [4];

    // Lane-indexed views of the flat input ports.
    logic [ADDR_W-1:0] inSelArr  [4];
    logic [DATA_W-1:0] inDataArr [4];

    assign inSelArr[0]  = inSel0;
    assign inSelArr[1]  = inSel1;
    assign inSelArr[2]  = inSel2;
    assign inSelArr[3]  = inSel3;
    assign inDataArr[0] = inData0;
    assign inDataArr[1] = inData1;
    assign inDataArr[2] = inData2;
    assign inDataArr[3] = inData3;

    // -------------------------------------------------------------------------
    // Pending-lane count
    // -------------------------------------------------------------------------
    logic [2:0] pendCount;

    // NOTE: every variable written in an always_comb gets a default at the top;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        pendCount = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pendCount = pendCount + {2'b00, pendMask[i]};
        end
    end

    // -------------------------------------------------------------------------
    // Chunk selection: walk the lanes in order and hand the first N_WRITE
    // pending ones to ports 0, 1, ... so the regfile sees a dense port set.
    // portLane[p] says which buffered lane port p carries this cycle.
    // -------------------------------------------------------------------------
    logic [0:3] chunkMask;
    logic [0:3] portValid;
    logic [1:0] portLane [4];
    logic [2:0] portCnt;

    always_comb begin
        chunkMask = '0;
        portValid = '0;
        portCnt   = 3'd0;
        for (int p = 0; p < 4; p++) begin
            portLane[p] = 2'd0;
        end
        for (int i = 0; i < 4; i++) begin
            if (pendMask[i] && (portCnt < NW)) begin
                portValid[portCnt[1:0]] = 1'b1;
                portLane[portCnt[1:0]]  = 2'(i);
                chunkMask[i]            = 1'b1;
                portCnt                 = portCnt + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write-port outputs, driven straight from the buffer. Unused ports are
    // forced to zero rather than showing stale buffer contents.
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] portSel  [4];
    logic [DATA_W-1:0] portData [4];

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            portSel[p]  = '0;
            portData[p] = '0;
            if (portValid[p]) begin
                portSel[p]  = selBuf[portLane[p]];
                portData[p] = dataBuf[portLane[p]];
            end
        end
    end

    assign commitVec     = portValid;
    assign writeSelect0  = portSel[0];
    assign writeSelect1  = portSel[1];
    assign writeSelect2  = portSel[2];
    assign writeSelect3  = portSel[3];
    assign writeData0    = portData[0];
    assign writeData1    = portData[1];
    assign writeData2    = portData[2];
    assign writeData3    = portData[3];

    // -------------------------------------------------------------------------
    // Handshake and status
    // -------------------------------------------------------------------------
    // Ready on the last drain cycle too: the incoming load replaces whatever
    // would remain after this cycle's chunk, which is nothing.
    assign inReady     = en && ((state == IDLE) || (pendCount <= NW));
    assign commitAllow = en && (state == DRAIN);
    assign busy        = (state == DRAIN);

    // Lanes in this cycle's chunk still count until the edge that writes them.
    always_comb begin
        queryPending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pendMask[i] && (selBuf[i] == queryReg)) begin
                queryPending = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state. pendMask and state move together: DRAIN exactly when
    // some lane is still pending after this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        pendNext  = pendMask;
        loadBuf   = 1'b0;
        stateNext = state;
        if (en) begin
            pendNext = pendMask & ~chunkMask;
            // A new group overrides the clear, so groups can run back to back.
            if (inValid && inReady) begin
                pendNext = inVec;
                loadBuf  = 1'b1;
            end
            stateNext = (pendNext != 4'b0000) ? DRAIN : IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pendMask <= '0;
            // NOTE: the sel/data buffer is small register storage, not a RAM, so
            // it is cleared on reset; this keeps write-port and query outputs
            // deterministic right after reset.
            for (int i = 0; i < 4; i++) begin
                selBuf[i]  <= '0;
                dataBuf[i] <= '0;
            end
        end else begin
            state    <= stateNext;
            pendMask <= pendNext;
            if (loadBuf) begin
                for (int i = 0; i < 4; i++) begin
                    selBuf[i]  <= inSelArr[i];
                    dataBuf[i] <= inDataArr[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_commit_sequencer
//
// Three instances (N_WRITE = 1, 2, 4) share one stimulus bus. Each cycle every
// instance is compared with a reference model that keeps the pending lanes as
// an ordered list and pops up to N_WRITE of them per enabled edge. A golden
// register file (from the model) and an observed register file (from the DUT
// write ports) are compared at the end.
// -----------------------------------------------------------------------------
module tb_regfile_commit_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int NINST  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } lane_t;

    // One directed row: inputs for a cycle plus the outputs expected before its edge.
    typedef struct packed {
        logic                   valid;
        logic [0:3]             vec;
        logic [3:0][ADDR_W-1:0] sel;
        logic [3:0][DATA_W-1:0] data;
        logic                   r0;
        logic                   a0;
        logic [0:3]             v0;
        logic [ADDR_W-1:0]      s0;
        logic [DATA_W-1:0]      d0;
        logic                   r1;
        logic [0:3]             v1;
        logic [ADDR_W-1:0]      s1a;
        logic [ADDR_W-1:0]      s1b;
        logic [DATA_W-1:0]      d1b;
    } row_t;

    localparam logic [DATA_W-1:0] DA = 32'hA0A0_000A;
    localparam logic [DATA_W-1:0] DB = 32'hB0B0_000B;
    localparam logic [DATA_W-1:0] DC = 32'hC0C0_000C;
    localparam logic [DATA_W-1:0] DD = 32'hD0D0_000D;
    localparam logic [DATA_W-1:0] DE = 32'hE0E0_000E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              en;
    logic              inValid;
    logic [0:3]        inVec;
    logic [ADDR_W-1:0] inSel  [4];
    logic [DATA_W-1:0] inData [4];
    logic [ADDR_W-1:0] queryReg;

    logic              inReadyW      [NINST];
    logic              commitAllowW  [NINST];
    logic [0:3]        commitVecW    [NINST];
    logic [ADDR_W-1:0] wSelW         [NINST][4];
    logic [DATA_W-1:0] wDataW        [NINST][4];
    logic              busyW         [NINST];
    logic              queryPendingW [NINST];

    for (genvar g = 0; g < NINST; g++) begin : gDut
        localparam int NWG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        regfile_commit_sequencer #(
            .N_WRITE(NWG),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .en          (en),
            .inValid     (inValid),
            .inReady     (inReadyW[g]),
            .inVec       (inVec),
            .inSel0      (inSel[0]),
            .inSel1      (inSel[1]),
            .inSel2      (inSel[2]),
            .inSel3      (inSel[3]),
            .inData0     (inData[0]),
            .inData1     (inData[1]),
            .inData2     (inData[2]),
            .inData3     (inData[3]),
            .commitAllow (commitAllowW[g]),
            .commitVec   (commitVecW[g]),
            .writeSelect0(wSelW[g][0]),
            .writeSelect1(wSelW[g][1]),
            .writeSelect2(wSelW[g][2]),
            .writeSelect3(wSelW[g][3]),
            .writeData0  (wDataW[g][0]),
            .writeData1  (wDataW[g][1]),
            .writeData2  (wDataW[g][2]),
            .writeData3  (wDataW[g][3]),
            .busy        (busyW[g]),
            .queryReg    (queryReg),
            .queryPending(queryPendingW[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: ordered list of pending lanes per instance.
    lane_t             mq    [NINST][4];
    int                mn    [NINST];
    logic [DATA_W-1:0] mdlRf [NINST][64];
    logic [DATA_W-1:0] dutRf [NINST][64];

    // Write-port values captured before the edge, applied to dutRf at the edge.
    logic              capAllow [NINST];
    logic [0:3]        capVec   [NINST];
    logic [ADDR_W-1:0] capSel   [NINST][4];
    logic [DATA_W-1:0] capData  [NINST][4];

    function automatic int nwOf(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic modelCompare();
        for (int g = 0; g < NINST; g++) begin
            int         nw;
            int         k;
            logic [0:3] ev;
            logic       qp;
            nw = nwOf(g);
            k  = (mn[g] < nw) ? mn[g] : nw;
            ev = '0;
            qp = 1'b0;
            check("inReady", g, 32'(inReadyW[g]), 32'(en && (mn[g] <= nw)));
            check("commitAllow", g, 32'(commitAllowW[g]), 32'(en && (mn[g] > 0)));
            check("busy", g, 32'(busyW[g]), 32'(mn[g] > 0));
            for (int p = 0; p < 4; p++) begin
                if (p < k) begin
                    ev[p] = 1'b1;
                    check("writeSelect", g, 32'(wSelW[g][p]), 32'(mq[g][p].sel));
                    check("writeData", g, wDataW[g][p], mq[g][p].data);
                end else begin
                    check("writeSelect", g, 32'(wSelW[g][p]), 32'd0);
                    check("writeData", g, wDataW[g][p], 32'd0);
                end
            end
            check("commitVec", g, 32'(commitVecW[g]), 32'(ev));
            for (int i = 0; i < mn[g]; i++) begin
                if (mq[g][i].sel == queryReg) qp = 1'b1;
            end
            check("queryPending", g, 32'(queryPendingW[g]), 32'(qp));
        end
    endtask

    task automatic modelUpdate();
        for (int g = 0; g < NINST; g++) begin
            int   nw;
            int   k;
            logic rdy;
            nw  = nwOf(g);
            k   = (mn[g] < nw) ? mn[g] : nw;
            rdy = en && (mn[g] <= nw);
            if (en && k > 0) begin
                for (int i = 0; i < k; i++) mdlRf[g][mq[g][i].sel] = mq[g][i].data;
                for (int i = 0; i + k < mn[g]; i++) mq[g][i] = mq[g][i + k];
                mn[g] = mn[g] - k;
            end
            if (reset) begin
                mn[g] = 0;
            end else if (en && inValid && rdy) begin
                mn[g] = 0;
                for (int i = 0; i < 4; i++) begin
                    if (inVec[i]) begin
                        mq[g][mn[g]] = '{sel: inSel[i], data: inData[i]};
                        mn[g]++;
                    end
                end
            end
        end
    endtask

    // Sample away from the active edge and compare against the model.
    task automatic sampleAndCheck();
        @(negedge clk);
        modelCompare();
        for (int g = 0; g < NINST; g++) begin
            capAllow[g] = commitAllowW[g];
            capVec[g]   = commitVecW[g];
            for (int p = 0; p < 4; p++) begin
                capSel[g][p]  = wSelW[g][p];
                capData[g][p] = wDataW[g][p];
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        // Ports are applied in order, so a higher port wins on a duplicate sel.
        for (int g = 0; g < NINST; g++) begin
            if (capAllow[g]) begin
                for (int p = 0; p < 4; p++) begin
                    if (capVec[g][p]) dutRf[g][capSel[g][p]] = capData[g][p];
                end
            end
        end
        modelUpdate();
        #1;
    endtask

    task automatic tick();
        sampleAndCheck();
        advance();
    endtask

    task automatic setGroup(input logic [0:3] v,
                            input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1,
                            input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] s3,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                            input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
        inValid   = 1'b1;
        inVec     = v;
        inSel[0]  = s0;  inSel[1]  = s1;  inSel[2]  = s2;  inSel[3]  = s3;
        inData[0] = d0;  inData[1] = d1;  inData[2] = d2;  inData[3] = d3;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        inVec   = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    row_t rows [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NINST; g++) begin
            mn[g] = 0;
            for (int r = 0; r < 64; r++) begin
                mdlRf[g][r] = '0;
                dutRf[g][r] = '0;
            end
        end
        reset    = 1'b1;
        en       = 1'b1;
        inValid  = 1'b0;
        inVec    = '0;
        queryReg = '0;
        for (int i = 0; i < 4; i++) begin
            inSel[i]  = '0;
            inData[i] = '0;
        end
        // DUT state is unknown before the first reset edge, so no comparisons here.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- Directed table: N_WRITE=1 (inst0) and N_WRITE=2 (inst1) drain the
        //      same 1011 group; a 1-lane group follows on inst0's last drain cycle.
        rows[0] = '{1'b1, 4'b1011, {6'd8, 6'd7, 6'd6, 6'd5}, {DD, DC, DB, DA},
                    1'b1, 1'b0, 4'b0000, 6'd0, 32'd0,
                    1'b1, 4'b0000, 6'd0, 6'd0, 32'd0};
        rows[1] = '{1'b0, 4'b0000, '0, '0,
                    1'b0, 1'b1, 4'b1000, 6'd5, DA,
                    1'b0, 4'b1100, 6'd5, 6'd7, DC};
        rows[2] = '{1'b0, 4'b0000, '0, '0,
                    1'b0, 1'b1, 4'b1000, 6'd7, DC,
                    1'b1, 4'b1000, 6'd8, 6'd0, 32'd0};
        rows[3] = '{1'b1, 4'b1000, {6'd0, 6'd0, 6'd0, 6'd9}, {32'd0, 32'd0, 32'd0, DE},
                    1'b1, 1'b1, 4'b1000, 6'd8, DD,
                    1'b1, 4'b0000, 6'd0, 6'd0, 32'd0};
        rows[4] = '{1'b0, 4'b0000, '0, '0,
                    1'b1, 1'b1, 4'b1000, 6'd9, DE,
                    1'b1, 4'b1000, 6'd9, 6'd0, 32'd0};
        rows[5] = '{1'b0, 4'b0000, '0, '0,
                    1'b1, 1'b0, 4'b0000, 6'd0, 32'd0,
                    1'b1, 4'b0000, 6'd0, 6'd0, 32'd0};

        for (int r = 0; r < 6; r++) begin
            inValid = rows[r].valid;
            inVec   = rows[r].vec;
            for (int i = 0; i < 4; i++) begin
                inSel[i]  = rows[r].sel[i];
                inData[i] = rows[r].data[i];
            end
            sampleAndCheck();
            check("tblReady", 0, 32'(inReadyW[0]), 32'(rows[r].r0));
            check("tblAllow", 0, 32'(commitAllowW[0]), 32'(rows[r].a0));
            check("tblVec", 0, 32'(commitVecW[0]), 32'(rows[r].v0));
            check("tblSel0", 0, 32'(wSelW[0][0]), 32'(rows[r].s0));
            check("tblData0", 0, wDataW[0][0], rows[r].d0);
            check("tblReady", 1, 32'(inReadyW[1]), 32'(rows[r].r1));
            check("tblVec", 1, 32'(commitVecW[1]), 32'(rows[r].v1));
            check("tblSel0", 1, 32'(wSelW[1][0]), 32'(rows[r].s1a));
            check("tblSel1", 1, 32'(wSelW[1][1]), 32'(rows[r].s1b));
            check("tblData1", 1, wDataW[1][1], rows[r].d1b);
            advance();
        end
        idle(4);

        // ---- en=0 freeze mid-drain, then reset mid-drain (inst0, N_WRITE=1).
        setGroup(4'b1011, 6'd5, 6'd6, 6'd7, 6'd8, DA, DB, DC, DD);
        tick();
        inValid  = 1'b0;
        queryReg = 6'd8;
        sampleAndCheck();
        check("frzPre", 0, wDataW[0][0], DA);
        advance();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sampleAndCheck();
            check("frzAllow", 0, 32'(commitAllowW[0]), 32'd0);
            check("frzVec", 0, 32'(commitVecW[0]), 32'(4'b1000));
            check("frzSel", 0, 32'(wSelW[0][0]), 32'd7);
            check("frzBusy", 0, 32'(busyW[0]), 32'd1);
            check("frzQuery", 0, 32'(queryPendingW[0]), 32'd1);
            advance();
        end
        en = 1'b1;
        sampleAndCheck();
        check("resumeAllow", 0, 32'(commitAllowW[0]), 32'd1);
        check("resumeData", 0, wDataW[0][0], DC);
        advance();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sampleAndCheck();
        check("rstAllow", 0, 32'(commitAllowW[0]), 32'd0);
        check("rstBusy", 0, 32'(busyW[0]), 32'd0);
        check("rstQuery", 0, 32'(queryPendingW[0]), 32'd0);
        advance();
        idle(2);

        // ---- Duplicate sels, N_WRITE=4 (inst2): one cycle, highest port wins.
        setGroup(4'b1111, 6'd3, 6'd3, 6'd3, 6'd3, 32'd1, 32'd2, 32'd3, 32'd4);
        queryReg = 6'd3;
        tick();
        inValid = 1'b0;
        sampleAndCheck();
        check("dupVec", 2, 32'(commitVecW[2]), 32'(4'b1111));
        check("dupSel3", 2, 32'(wSelW[2][3]), 32'd3);
        check("dupData3", 2, wDataW[2][3], 32'd4);
        check("dupQuery", 2, 32'(queryPendingW[2]), 32'd1);
        advance();
        sampleAndCheck();
        check("dupQueryAfter", 2, 32'(queryPendingW[2]), 32'd0);
        check("dupBusyAfter", 2, 32'(busyW[2]), 32'd0);
        check("dupRf3", 2, dutRf[2][3], 32'd4);
        advance();
        idle(4);

        // ---- Empty group: handshake completes, nothing is ever written.
        setGroup(4'b0000, 6'd1, 6'd2, 6'd3, 6'd4, DA, DB, DC, DD);
        sampleAndCheck();
        check("emptyReady", 0, 32'(inReadyW[0]), 32'd1);
        advance();
        inValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sampleAndCheck();
            check("emptyBusy", 0, 32'(busyW[0]), 32'd0);
            check("emptyAllow", 0, 32'(commitAllowW[0]), 32'd0);
            advance();
        end

        // ---- Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 63) == 0);
            en      = ($urandom_range(0, 7) != 0);
            inValid = ($urandom_range(0, 9) < 6);
            inVec   = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                inSel[i]  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                        : 6'($urandom_range(0, 7));
                inData[i] = $urandom;
            end
            queryReg = 6'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;
        en    = 1'b1;
        idle(6);

        for (int g = 0; g < NINST; g++) begin
            for (int r = 0; r < 64; r++) begin
                check($sformatf("rf%0d", r), g, dutRf[g][r], mdlRf[g][r]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
